// File: rtl/mdu_pkg.sv
// Shared MDU definitions: funct codes, sequencer state encoding and op-class helpers.
// MDU_DIV_EN enables the divide ops in the start-op decode.
package mdu_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_start_op(input logic [5:0] f);
`ifdef MDU_DIV_EN
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
`else
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
`endif
  endfunction

  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step, or restoring-divide step when MDU_DIV_EN is defined.
module mdu_step #(
  parameter int WIDTH = 32
) (
`ifdef MDU_DIV_EN
  input  logic               is_div_i,
`endif
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   mul_next;
`ifdef MDU_DIV_EN
  logic [WIDTH:0]       top;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   div_next;
`endif

  // Multiply: low half holds the remaining multiplier bits, product grows in from the top.
  always_comb begin
    sum      = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    mul_next = {sum, acc_i[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // Divide: remainder in the top half, dividend bits shift out of the low half as quotient bits shift in.
    top      = acc_i[2*WIDTH-1:WIDTH-1];
    diff     = top - {1'b0, opnd_i};
    div_next = diff[WIDTH] ? {top[WIDTH-1:0],  acc_i[WIDTH-2:0], 1'b0}
                           : {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    acc_o    = is_div_i ? div_next : mul_next;
`else
    acc_o    = mul_next;
`endif
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls EX while an operation is in flight.
// MDU_DIV_EN adds DIV/DIVU and the div_zero_o flag; without it DIV/DIVU are ignored.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e          state, state_nx;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  acc, acc_step, prod_fix;
  logic [WIDTH-1:0]    opb, mag_a, mag_b, res_hi, res_lo;
  logic                sign_a, sign_b, neg_a, neg_b;
  logic                accept, start_op, finish, last_step;
`ifdef MDU_DIV_EN
  logic                is_div, div_zero;
  logic [WIDTH-1:0]    rem_mag, quo_mag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start_op) state_nx = ST_CALC;
      ST_CALC: begin
        if (flush_i)        state_nx = ST_IDLE;
        else if (last_step) state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state != ST_IDLE);
    stall_o   = busy_o & op_valid_i;
    accept    = (state == ST_IDLE) & op_valid_i & ~flush_i;
    start_op  = accept & is_start_op(funct_i);
    finish    = (state == ST_FIX) & ~flush_i;
    last_step = (cnt == CW'(WIDTH - 1));
    rd_data_o = '0;
    if (funct_i == FUNCT_MFHI)      rd_data_o = hi_o;
    else if (funct_i == FUNCT_MFLO) rd_data_o = lo_o;
  end

  // Operands are reduced to unsigned magnitudes; signs are reapplied in FIX.
  assign neg_a = is_signed_op(funct_i) & rs_i[WIDTH-1];
  assign neg_b = is_signed_op(funct_i) & rt_i[WIDTH-1];
  assign mag_a = neg_a ? -rs_i : rs_i;
  assign mag_b = neg_b ? -rt_i : rt_i;

  mdu_step #(.WIDTH(WIDTH)) u_step (
`ifdef MDU_DIV_EN
    .is_div_i (is_div),
`endif
    .acc_i    (acc),
    .opnd_i   (opb),
    .acc_o    (acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opb    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
`ifdef MDU_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (start_op) begin
      acc    <= {{WIDTH{1'b0}}, mag_a};
      opb    <= mag_b;
      sign_a <= neg_a;
      sign_b <= neg_b;
      cnt    <= '0;
`ifdef MDU_DIV_EN
      is_div <= (funct_i == FUNCT_DIV) || (funct_i == FUNCT_DIVU);
`endif
    end else if (state == ST_CALC) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
    end
  end

  // With a zero divisor the remainder naturally ends up as the dividend magnitude.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    div_zero = (opb == '0);
    rem_mag  = acc[2*WIDTH-1:WIDTH];
    quo_mag  = acc[WIDTH-1:0];
    if (is_div) begin
      res_hi = sign_a ? -rem_mag : rem_mag;
      res_lo = div_zero ? '1 : ((sign_a ^ sign_b) ? -quo_mag : quo_mag);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= finish;
      if (finish) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end else if (accept && funct_i == FUNCT_MTHI) begin
        hi_o <= rs_i;
      end else if (accept && funct_i == FUNCT_MTLO) begin
        lo_o <= rs_i;
      end
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_zero_o <= 1'b0;
    else        div_zero_o <= finish & is_div & div_zero;
  end
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector bench for mdu_sequencer; divide vectors run only when MDU_DIV_EN is defined.
module tb_mdu_sequencer;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] rs = '0, rt = '0;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo, rd_data;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid_i (op_valid),
    .funct_i    (funct),
    .rs_i       (rs),
    .rt_i       (rt),
    .flush_i    (flush),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo),
    .rd_data_o  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1;
    funct    = f;
    rs       = a;
    rt       = b;
    #1;
  endtask

  task automatic idleInputs();
    op_valid = 1'b0;
    funct    = '0;
    rs       = '0;
    rt       = '0;
  endtask

  // Starts an op, optionally presents MFLO at busy cycle mf_at, and checks the finished result.
  task automatic runOp(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ez, input int mf_at);
    int   cycles;
    logic stall_ok;
    applyStimulus(f, a, b);
    checkOutput({tag, " stall at start"}, stall, 0);
    @(negedge clk);
    idleInputs();
    cycles   = 0;
    stall_ok = 1'b1;
    while (busy === 1'b1 && cycles < 200) begin
      if (cycles == mf_at) begin
        op_valid = 1'b1;
        funct    = F_MFLO;
      end
      #1;
      if (op_valid && stall !== 1'b1) stall_ok = 1'b0;
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, " busy cycles"}, cycles, 33);
    checkOutput({tag, " done"}, done, 1);
    checkOutput({tag, " hi"}, hi, eh);
    checkOutput({tag, " lo"}, lo, el);
    checkOutput({tag, " div_zero"}, div_zero, ez);
    if (mf_at >= 0) begin
      checkOutput({tag, " stall held"}, stall_ok, 1);
      checkOutput({tag, " mflo data"}, rd_data, el);
      checkOutput({tag, " mflo no stall"}, stall, 0);
      idleInputs();
    end
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    checkOutput({tag, " done pulse ends"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic done_seen;

    #12;
    checkOutput("reset hi", hi, 0);
    checkOutput("reset lo", lo, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset div_zero", div_zero, 0);
    checkOutput("reset rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(F_MTHI, 32'h0000_1234, 32'h0);
    @(negedge clk);
    idleInputs();
    checkOutput("mthi hi", hi, 32'h0000_1234);
    checkOutput("mthi lo untouched", lo, 0);
    applyStimulus(F_MTLO, 32'h0000_5678, 32'h0);
    @(negedge clk);
    idleInputs();
    checkOutput("mtlo lo", lo, 32'h0000_5678);

    applyStimulus(F_MFHI, 32'h0, 32'h0);
    checkOutput("mfhi data", rd_data, 32'h0000_1234);
    checkOutput("mfhi no stall", stall, 0);
    @(negedge clk);
    idleInputs();
    checkOutput("mfhi hi unchanged", hi, 32'h0000_1234);

    runOp("mult -3*7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 5);
    runOp("multu max*max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
    runOp("mult min*min", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1);
    runOp("mult max*-1", F_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, -1);

    applyStimulus(F_MULT, 32'd5, 32'd5);
    @(negedge clk);
    idleInputs();
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush busy", busy, 0);
    checkOutput("flush hi kept", hi, model_hi);
    checkOutput("flush lo kept", lo, model_lo);
    done_seen = done;
    repeat (40) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    checkOutput("flush no done", done_seen, 0);

    applyStimulus(F_MULT, 32'd5, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idleInputs();
    checkOutput("idle flush blocks start", busy, 0);

    applyStimulus(F_ADD, 32'd1, 32'd2);
    @(negedge clk);
    idleInputs();
    checkOutput("unknown funct ignored", busy, 0);
    checkOutput("unknown funct hi kept", hi, model_hi);

`ifdef MDU_DIV_EN
    runOp("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
    runOp("div 7/-2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -1);
    runOp("divu 7/0", F_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1, -1);
    runOp("div -7/0", F_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, -1);
    runOp("div overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);
    runOp("divu max/10", F_DIVU, 32'hFFFF_FFFF, 32'd10, 32'h0000_0005, 32'h1999_9999, 1'b0, -1);
`else
    applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div disabled stall", stall, 0);
    @(negedge clk);
    idleInputs();
    checkOutput("div disabled busy", busy, 0);
    checkOutput("div disabled hi", hi, model_hi);
    checkOutput("div disabled lo", lo, model_lo);
    applyStimulus(F_DIVU, 32'd7, 32'd0);
    @(negedge clk);
    idleInputs();
    checkOutput("divu disabled busy", busy, 0);
    checkOutput("divu disabled div_zero", div_zero, 0);
`endif

    applyStimulus(F_MULT, 32'hFFFF_FFFD, 32'd7);
    @(negedge clk);
    idleInputs();
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset hi", hi, 0);
    checkOutput("async reset lo", lo, 0);
    checkOutput("async reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;

    runOp("multu after reset", F_MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
